// File: rtl/fft_r22sdf_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft_r22sdf_frame_ctrl
//
// Frame sequencer in front of the radix-2^2 SDF FFT core. On a start request
// it streams exactly N samples from a valid/ready source into the core with a
// gap-free clock enable. It then keeps the enable high with zero input until
// the core raises sync, captures the N output bins that follow, and reports
// done or error.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               frame request (only honoured in IDLE)
//   busy_o                high outside IDLE
//   done_o                one-cycle pulse on clean frame completion
//   err_o                 sticky error, cleared when the next start is accepted
//   frame_cnt_o           completed-frame counter (wraps)
//   s_valid_i/s_ready_o   source handshake, s_re_i/s_im_i source sample
//   fft_ce_o              core clock enable (owned by this block)
//   fft_re_o/fft_im_o     core input sample
//   fft_sync_i/fft_ctr_i  core output sync and bin index
//   fft_re_i/fft_im_i     core output bin value
//   m_valid_o, m_ctr_o,
//   m_re_o/m_im_o         captured output bins (1-cycle capture latency)
//   state_o               current FSM state, for debug and checkers
//
// Handshake: a source sample transfers on any rising clock edge where
// s_valid_i and s_ready_o are both high. s_ready_o is combinational and is
// high exactly while the FSM is in LOAD. The source may not withdraw valid
// once the first sample of a frame has transferred: a gap before the Nth
// sample aborts the frame, because the core restarts its counters when its
// clock enable drops.
// ---------------------------------------------------------------------------
module fft_r22sdf_frame_ctrl #(
  parameter int N            = 1024,
  parameter int N_LOG2       = 10,
  parameter int INPUT_WIDTH  = 14,
  parameter int OUTPUT_WIDTH = 25,
  parameter int TIMEOUT      = 4096
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [15:0]             frame_cnt_o,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [INPUT_WIDTH-1:0]  s_re_i,
  input  logic [INPUT_WIDTH-1:0]  s_im_i,
  output logic                    fft_ce_o,
  output logic [INPUT_WIDTH-1:0]  fft_re_o,
  output logic [INPUT_WIDTH-1:0]  fft_im_o,
  input  logic                    fft_sync_i,
  input  logic [N_LOG2-1:0]       fft_ctr_i,
  input  logic [OUTPUT_WIDTH-1:0] fft_re_i,
  input  logic [OUTPUT_WIDTH-1:0] fft_im_i,
  output logic                    m_valid_o,
  output logic [N_LOG2-1:0]       m_ctr_o,
  output logic [OUTPUT_WIDTH-1:0] m_re_o,
  output logic [OUTPUT_WIDTH-1:0] m_im_o,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int                LAT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [N_LOG2-1:0] CNT_LAST = N_LOG2'(N - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(TIMEOUT - 1);

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [15:0]             r_frame_cnt;
  logic                    r_ce;
  logic [INPUT_WIDTH-1:0]  r_re;
  logic [INPUT_WIDTH-1:0]  r_im;
  logic                    r_m_valid;
  logic [N_LOG2-1:0]       r_m_ctr;
  logic [OUTPUT_WIDTH-1:0] r_m_re;
  logic [OUTPUT_WIDTH-1:0] r_m_im;
  logic [N_LOG2-1:0]       r_in_cnt;
  logic [N_LOG2-1:0]       r_out_cnt;
  logic [LAT_W-1:0]        r_lat_cnt;
  logic                    r_started;  // first sample of this frame accepted

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
      r_ce        <= 1'b0;
      r_re        <= '0;
      r_im        <= '0;
      r_m_valid   <= 1'b0;
      r_m_ctr     <= '0;
      r_m_re      <= '0;
      r_m_im      <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_lat_cnt   <= '0;
      r_started   <= 1'b0;
    end else begin
      // Pulses default low; only a capture or completion raises them.
      r_done    <= 1'b0;
      r_m_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_ce <= 1'b0;
          if (start_i) begin
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_in_cnt  <= '0;
            r_started <= 1'b0;
            r_state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (s_valid_i) begin
            r_ce      <= 1'b1;
            r_re      <= s_re_i;
            r_im      <= s_im_i;
            r_started <= 1'b1;
            r_in_cnt  <= r_in_cnt + 1'b1;
            if (r_in_cnt == CNT_LAST) begin
              r_lat_cnt <= '0;
              r_out_cnt <= '0;
              r_state   <= S_FLUSH;
            end
          end else begin
            // Before the first sample we simply wait; afterwards a gap is
            // an underrun and the frame is abandoned.
            r_ce <= 1'b0;
            if (r_started) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end

        S_FLUSH: begin
          r_re <= '0;
          r_im <= '0;
          if (fft_sync_i) begin
            r_m_valid <= 1'b1;
            r_m_ctr   <= fft_ctr_i;
            r_m_re    <= fft_re_i;
            r_m_im    <= fft_im_i;
            r_out_cnt <= r_out_cnt + 1'b1;
            r_state   <= S_DRAIN;
          end else if (r_lat_cnt == LAT_LAST) begin
            r_err   <= 1'b1;
            r_ce    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end

        S_DRAIN: begin
          r_re <= '0;
          r_im <= '0;
          if (fft_sync_i) begin
            r_m_valid <= 1'b1;
            r_m_ctr   <= fft_ctr_i;
            r_m_re    <= fft_re_i;
            r_m_im    <= fft_im_i;
            r_out_cnt <= r_out_cnt + 1'b1;
            if (r_out_cnt == CNT_LAST) begin
              r_ce        <= 1'b0;
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 1'b1;
              r_state     <= S_DONE;
            end
          end else begin
            // Sync fell before all bins arrived.
            r_err   <= 1'b1;
            r_ce    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_DONE: begin
          // One ce-low cycle here plus the IDLE cycle gives the core a gap
          // of at least two cycles before the next frame.
          r_ce    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_ce    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign s_ready_o   = (r_state == S_LOAD);
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign frame_cnt_o = r_frame_cnt;
  assign fft_ce_o    = r_ce;
  assign fft_re_o    = r_re;
  assign fft_im_o    = r_im;
  assign m_valid_o   = r_m_valid;
  assign m_ctr_o     = r_m_ctr;
  assign m_re_o      = r_m_re;
  assign m_im_o      = r_m_im;
  assign state_o     = r_state;

endmodule
